// File: rtl/idli_pkg.sv
// Shared core types plus the UART FSM state encodings and frame constants.
package idli_pkg;

  typedef logic [1:0] ctr_t;
  typedef logic [3:0] slice_t;

  typedef enum logic [2:0] {TxIdle, TxLoad, TxStart, TxData, TxStop} uart_tx_state_t;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} uart_rx_state_t;

  // Start + 8 data + stop.
  localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/idli_uart_rx_m.sv
// UART receiver: input synchroniser, 8N1 deframing FSM and bit timer.
// Pulses o_rx_done for one cycle at the stop-bit sample.
module idli_uart_rx_m import idli_pkg::*; #(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic       i_top_gck,
  input  logic       i_top_rst_n,
  input  logic       i_uart_rx,
  output logic       o_rx_done,
  output logic       o_rx_stop_ok,
  output logic [7:0] o_rx_byte
);

  localparam int unsigned TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] BitEnd  = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HalfEnd = TW'(BAUD_DIV / 2 - 1);

  logic           sync1_q, sync2_q;
  uart_rx_state_t state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [7:0]     shift_q, shift_d;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + 1'b1;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    o_rx_done    = 1'b0;
    o_rx_stop_ok = 1'b0;
    unique case (state_q)
      RxIdle: begin
        timer_d = '0;
        if (!sync2_q) state_d = RxStart;
      end
      RxStart: begin
        // Mid-start-bit check; a high line here was only a glitch.
        if (timer_q == HalfEnd) begin
          timer_d = '0;
          cnt_d   = '0;
          state_d = sync2_q ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (timer_q == BitEnd) begin
          timer_d = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 3'd7) state_d = RxStop;
        end
      end
      RxStop: begin
        if (timer_q == BitEnd) begin
          timer_d      = '0;
          o_rx_done    = 1'b1;
          o_rx_stop_ok = sync2_q;
          state_d      = RxIdle;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RxIdle;
      timer_q <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= i_uart_rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign o_rx_byte = shift_q;

endmodule

// File: rtl/idli_uart_m.sv
// Slice-serial UART: core-facing byte buffers and 8N1 transmitter; the
// receiver lives in idli_uart_rx_m.
module idli_uart_m import idli_pkg::*; #(
  parameter int unsigned BAUD_DIV = 16
) (
  input  logic   i_top_gck,
  input  logic   i_top_rst_n,
  input  ctr_t   i_uart_ctr,
  input  logic   i_uart_wr_en,
  input  logic   i_uart_rd_en,
  input  slice_t i_uart_slice,
  output slice_t o_uart_slice,
  output logic   o_uart_tx_rdy,
  output logic   o_uart_rx_vld,
  output logic   o_uart_rx_err,
  input  logic   i_uart_rx,
  output logic   o_uart_tx
);

  localparam int unsigned TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] BitEnd = TW'(BAUD_DIV - 1);
  localparam logic [2:0] LastData = 3'(UART_FRAME_BITS - 3);

  uart_tx_state_t tx_state_q, tx_state_d;
  logic [TW-1:0]  tx_timer_q, tx_timer_d;
  logic [2:0]     tx_cnt_q, tx_cnt_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic           tx_q, tx_d;
  logic           tx_rdy_q, tx_rdy_d;
  logic           wr_acc;

  logic           rd_act_q, rd_act_d;
  logic [7:0]     rx_buf_q, rx_buf_d;
  logic           rx_vld_q, rx_vld_d;
  logic           rx_err_q, rx_err_d;
  logic           rd_acc, rd_end;
  logic           rx_done, rx_stop_ok;
  logic [7:0]     rx_byte;

  idli_uart_rx_m #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .i_top_gck   (i_top_gck),
    .i_top_rst_n (i_top_rst_n),
    .i_uart_rx   (i_uart_rx),
    .o_rx_done   (rx_done),
    .o_rx_stop_ok(rx_stop_ok),
    .o_rx_byte   (rx_byte)
  );

  assign wr_acc = (i_uart_ctr == 2'd0) && i_uart_wr_en && tx_rdy_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_cnt_d   = tx_cnt_q;
    tx_byte_d  = tx_byte_q;
    tx_d       = tx_q;
    tx_rdy_d   = tx_rdy_q;
    unique case (tx_state_q)
      TxIdle: begin
        if (wr_acc) begin
          tx_byte_d[3:0] = i_uart_slice;
          tx_rdy_d       = 1'b0;
          tx_state_d     = TxLoad;
        end
      end
      TxLoad: begin
        if (i_uart_ctr == 2'd1) tx_byte_d[7:4] = i_uart_slice;
        if (i_uart_ctr == 2'd3) begin
          tx_timer_d = '0;
          tx_d       = 1'b0;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        tx_timer_d = tx_timer_q + 1'b1;
        if (tx_timer_q == BitEnd) begin
          tx_timer_d = '0;
          tx_cnt_d   = '0;
          tx_d       = tx_byte_q[0];
          tx_state_d = TxData;
        end
      end
      TxData: begin
        tx_timer_d = tx_timer_q + 1'b1;
        if (tx_timer_q == BitEnd) begin
          tx_timer_d = '0;
          if (tx_cnt_q == LastData) begin
            tx_d       = 1'b1;
            tx_state_d = TxStop;
          end else begin
            tx_cnt_d  = tx_cnt_q + 1'b1;
            tx_byte_d = {1'b0, tx_byte_q[7:1]};
            tx_d      = tx_byte_q[1];
          end
        end
      end
      TxStop: begin
        tx_timer_d = tx_timer_q + 1'b1;
        if (tx_timer_q == BitEnd) begin
          tx_timer_d = '0;
          tx_rdy_d   = 1'b1;
          tx_state_d = TxIdle;
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  assign rd_acc = (i_uart_ctr == 2'd0) && i_uart_rd_en && rx_vld_q;
  assign rd_end = rd_act_q && (i_uart_ctr == 2'd3);

  always_comb begin
    rd_act_d = rd_act_q;
    rx_buf_d = rx_buf_q;
    rx_vld_d = rx_vld_q;
    rx_err_d = rx_err_q;
    if (i_uart_ctr == 2'd0) begin
      rd_act_d = rd_acc;
    end else if (rd_end) begin
      rd_act_d = 1'b0;
    end
    if (rd_end) begin
      rx_vld_d = 1'b0;
      rx_err_d = 1'b0;
    end
    // A byte landing on the read's final slice replaces the one just consumed.
    if (rx_done) begin
      if (!rx_stop_ok) begin
        rx_err_d = 1'b1;
      end else if (!rx_vld_q || rd_end) begin
        rx_buf_d = rx_byte;
        rx_vld_d = 1'b1;
      end else begin
        rx_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    o_uart_slice = '0;
    if (rd_acc || rd_act_q) begin
      unique case (i_uart_ctr)
        2'd0:    o_uart_slice = rx_buf_q[3:0];
        2'd1:    o_uart_slice = rx_buf_q[7:4];
        default: o_uart_slice = '0;
      endcase
    end
  end

  always_ff @(posedge i_top_gck or negedge i_top_rst_n) begin
    if (!i_top_rst_n) begin
      tx_state_q <= TxIdle;
      tx_timer_q <= '0;
      tx_cnt_q   <= '0;
      tx_byte_q  <= '0;
      tx_q       <= 1'b1;
      tx_rdy_q   <= 1'b1;
      rd_act_q   <= 1'b0;
      rx_buf_q   <= '0;
      rx_vld_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_byte_q  <= tx_byte_d;
      tx_q       <= tx_d;
      tx_rdy_q   <= tx_rdy_d;
      rd_act_q   <= rd_act_d;
      rx_buf_q   <= rx_buf_d;
      rx_vld_q   <= rx_vld_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign o_uart_tx     = tx_q;
  assign o_uart_tx_rdy = tx_rdy_q;
  assign o_uart_rx_vld = rx_vld_q;
  assign o_uart_rx_err = rx_err_q;

endmodule

// File: tb/tb_idli_uart_m.sv
// Bench for idli_uart_m at BAUD_DIV=4: random TX/RX bytes against a
// frame-level model of the line and the receive buffer.
module tb_idli_uart_m;
  import idli_pkg::*;

  localparam int unsigned BAUD = 4;
  localparam int unsigned FRAME_CYC = 10 * BAUD;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  ctr_t   ctr = 2'd0;
  logic   wr_en = 1'b0;
  logic   rd_en = 1'b0;
  slice_t slice_in = '0;
  slice_t slice_out;
  logic   tx_rdy, rx_vld, rx_err, tx;
  logic   rx = 1'b1;

  int n_tests = 0;
  int n_fail = 0;

  // Receive-buffer model.
  logic [7:0] m_buf = 8'h00;
  logic       m_vld = 1'b0;
  logic       m_err = 1'b0;

  idli_uart_m #(
    .BAUD_DIV(BAUD)
  ) dut (
    .i_top_gck    (clk),
    .i_top_rst_n  (rst_n),
    .i_uart_ctr   (ctr),
    .i_uart_wr_en (wr_en),
    .i_uart_rd_en (rd_en),
    .i_uart_slice (slice_in),
    .o_uart_slice (slice_out),
    .o_uart_tx_rdy(tx_rdy),
    .o_uart_rx_vld(rx_vld),
    .o_uart_rx_err(rx_err),
    .i_uart_rx    (rx),
    .o_uart_tx    (tx)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 ctr = ctr + 2'd1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic to_ctr0();
    @(negedge clk);
    for (int i = 0; i < 4 && ctr != 2'd0; i++) @(negedge clk);
  endtask

  // Write byte b (optionally with a read in the same window), retry a write
  // while busy, and watch the whole frame cycle by cycle.
  task automatic tx_frame(input logic [7:0] b, input bit with_read);
    logic [7:0] rb;
    logic       rd;
    logic       e_tx, e_rdy;
    slice_t     e_sl;
    rb = m_buf;
    rd = with_read && m_vld;
    to_ctr0();
    wr_en = 1'b1;
    rd_en = with_read;
    slice_in = b[3:0];
    for (int k = 0; k <= int'(FRAME_CYC) + 8; k++) begin
      if (k > 0) @(negedge clk);
      case (k)
        0: ;
        1: begin wr_en = 1'b0; rd_en = 1'b0; slice_in = b[7:4]; end
        4: begin wr_en = 1'b1; slice_in = ~b[3:0]; end
        5: begin wr_en = 1'b0; slice_in = ~b[7:4]; end
        default: slice_in = slice_t'($urandom);
      endcase
      #3;
      e_tx  = (k >= 4 && k < 4 + int'(FRAME_CYC)) ? frame_bit(b, (k - 4) / int'(BAUD)) : 1'b1;
      e_rdy = (k >= 1 && k < 4 + int'(FRAME_CYC)) ? 1'b0 : 1'b1;
      e_sl  = (rd && k == 0) ? rb[3:0] : (rd && k == 1) ? rb[7:4] : 4'h0;
      n_tests++;
      if (tx !== e_tx) begin
        n_fail++;
        $display("FAIL tx_line byte=%h cycle=%0d got %b want %b", b, k, tx, e_tx);
      end
      n_tests++;
      if (tx_rdy !== e_rdy) begin
        n_fail++;
        $display("FAIL tx_rdy byte=%h cycle=%0d got %b want %b", b, k, tx_rdy, e_rdy);
      end
      n_tests++;
      if (slice_out !== e_sl) begin
        n_fail++;
        $display("FAIL tx_slice byte=%h cycle=%0d got %h want %h", b, k, slice_out, e_sl);
      end
    end
    if (rd) begin
      m_vld = 1'b0;
      m_err = 1'b0;
    end
    n_tests++;
    if (rx_vld !== m_vld || rx_err !== m_err) begin
      n_fail++;
      $display("FAIL tx_rx_status got vld=%b err=%b want vld=%b err=%b",
               rx_vld, rx_err, m_vld, m_err);
    end
  endtask

  // Drive one 8N1 frame on rx, then apply the buffer rules to the model.
  task automatic rx_frame(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = (i == 9) ? stop : frame_bit(b, i);
      repeat (BAUD - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    if (!stop) m_err = 1'b1;
    else if (m_vld) m_err = 1'b1;
    else begin
      m_buf = b;
      m_vld = 1'b1;
    end
    #3;
    n_tests++;
    if (rx_vld !== m_vld || rx_err !== m_err) begin
      n_fail++;
      $display("FAIL rx_status byte=%h stop=%b got vld=%b err=%b want vld=%b err=%b",
               b, stop, rx_vld, rx_err, m_vld, m_err);
    end
  endtask

  task automatic rx_read();
    logic [7:0] rb;
    logic       rd;
    slice_t     e_sl;
    rb = m_buf;
    rd = m_vld;
    to_ctr0();
    rd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) rd_en = 1'b0;
      #3;
      if (k < 4) begin
        e_sl = (rd && k == 0) ? rb[3:0] : (rd && k == 1) ? rb[7:4] : 4'h0;
        n_tests++;
        if (slice_out !== e_sl) begin
          n_fail++;
          $display("FAIL read_slice ctr=%0d got %h want %h", k, slice_out, e_sl);
        end
      end else if (k == 4) begin
        if (rd) begin
          m_vld = 1'b0;
          m_err = 1'b0;
        end
        n_tests++;
        if (rx_vld !== m_vld || rx_err !== m_err) begin
          n_fail++;
          $display("FAIL read_status got vld=%b err=%b want vld=%b err=%b",
                   rx_vld, rx_err, m_vld, m_err);
        end
      end else begin
        n_tests++;
        if (slice_out !== 4'h0) begin
          n_fail++;
          $display("FAIL read_idle_slice got %h want 0", slice_out);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #3;
    n_tests++;
    if ({tx, tx_rdy, rx_vld, rx_err, slice_out} !== {1'b1, 1'b1, 1'b0, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_state got tx=%b rdy=%b vld=%b err=%b slice=%h want 1 1 0 0 0",
               tx, tx_rdy, rx_vld, rx_err, slice_out);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_tx();
    tx_frame(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) tx_frame(8'($urandom), 1'b0);
  endtask

  task automatic test_rx();
    rx_frame(8'h3C, 1'b1);
    rx_read();
    rx_read();
    for (int i = 0; i < 3; i++) begin
      rx_frame(8'($urandom), 1'b1);
      rx_read();
    end
  endtask

  task automatic test_rx_errors();
    rx_frame(8'($urandom), 1'b0);
    rx_frame(8'($urandom), 1'b1);
    rx_read();
    rx_frame(8'h11, 1'b1);
    rx_frame(8'h22, 1'b1);
    test_glitch();
    rx_read();
    test_glitch();
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BAUD) @(negedge clk);
    #3;
    n_tests++;
    if (rx_vld !== m_vld || rx_err !== m_err) begin
      n_fail++;
      $display("FAIL glitch got vld=%b err=%b want vld=%b err=%b", rx_vld, rx_err, m_vld, m_err);
    end
  endtask

  task automatic test_concurrent();
    rx_frame(8'($urandom), 1'b1);
    tx_frame(8'($urandom), 1'b1);
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b;
    b = 8'($urandom);
    rx_frame(8'($urandom), 1'b1);
    to_ctr0();
    wr_en = 1'b1;
    slice_in = b[3:0];
    @(negedge clk);
    wr_en = 1'b0;
    slice_in = b[7:4];
    // Land in the middle of data bit 3 (frame bit 4).
    repeat (3 + 4 * BAUD + 1) @(negedge clk);
    rst_n = 1'b0;
    m_vld = 1'b0;
    m_err = 1'b0;
    #1;
    n_tests++;
    if ({tx, tx_rdy, rx_vld, rx_err} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_mid_tx got tx=%b rdy=%b vld=%b err=%b want 1 1 0 0",
               tx, tx_rdy, rx_vld, rx_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (FRAME_CYC) @(negedge clk);
    #3;
    n_tests++;
    if (tx !== 1'b1 || tx_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_no_resume got tx=%b rdy=%b want 1 1", tx, tx_rdy);
    end
    tx_frame(8'($urandom), 1'b0);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_rx_errors();
    test_concurrent();
    test_reset_mid_tx();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
